branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- IF-side dynamic branch predictor and the consumer of the EX-stage branch feedback interface.
- Supplies the taken/not-taken guess carried down the pipeline as the EX stage's branch_taken input, plus a table index carried alongside it.
- Trains a table of 2-bit saturating counters from EX feedback: fb_valid, the prediction that was made, and the mispredict flag.
- Keeps saturating performance counters for branches and mispredictions.

Parameters:
IDX_W, 6, table index width; table depth 2**IDX_W entries
CNT_INIT, 2'b01, reset value of every counter (weakly not-taken)

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
if_pc  input  32  PC of the instruction currently in IF
pred_taken  output  1  prediction for if_pc: 1 = taken
pred_idx  output  IDX_W  table index used for the prediction; piped to EX with the instruction
fb_valid  input  1  EX feedback valid: a resolved, non-stalled branch
fb_idx  input  IDX_W  pred_idx originally issued for the resolved branch
fb_pred_taken  input  1  prediction originally issued for the resolved branch
fb_mispredict  input  1  EX says the prediction was wrong
stat_branches  output  32  count of fb_valid cycles
stat_mispredicts  output  32  count of fb_valid cycles with fb_mispredict=1

Behaviour:
- Storage:
  - Counter table cnt[0 .. 2**IDX_W-1], 2 bits each.
  - Stat registers, 32 bits each.
- Reset, synchronous (clock edge with rst_n=0):
  - Every cnt entry = CNT_INIT.
  - stat_branches = 0, stat_mispredicts = 0.
  - Reset overrides a same-cycle fb_valid; no update is applied.
  - Reset mid-operation discards all training.
- Index: pred_idx = if_pc[IDX_W:1]. Bit 0 is ignored because of 2-byte compressed alignment.
- Prediction is combinational, zero latency:
  - pred_taken = cnt[pred_idx][1].
  - It is a pure function of if_pc and table state, so IF stalls need no handling.
- Actual outcome: act = fb_pred_taken XOR fb_mispredict.
- Update on a clock edge with fb_valid=1, rst_n=1:
  - act=1: cnt[fb_idx] = min(cnt+1, 3).
  - act=0: cnt[fb_idx] = max(cnt-1, 0).
  - Counter states: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- fb_valid=0: table and stats hold.
- Same-cycle read and write of the same index: pred_taken shows the pre-update value. There is no write bypass; the new value is visible from the next cycle.
- Stats:
  - stat_branches increments on every fb_valid.
  - stat_mispredicts increments on fb_valid and fb_mispredict.
  - Both saturate at 32'hFFFF_FFFF; no wrap.
  - Both are registered outputs.
- fb_mispredict and fb_pred_taken are ignored when fb_valid=0.

Optional Feature:
- Macro: BP_GSHARE_EN.
- Defined:
  - Adds an IDX_W-bit global history register ghr, reset to 0.
  - pred_idx = if_pc[IDX_W:1] XOR ghr.
  - On each update, ghr is shifted left with act in bit 0; the new ghr affects pred_idx from the next cycle.
  - Training uses fb_idx as delivered, so the index is consistent with prediction time.
- Undefined:
  - No ghr register.
  - pred_idx is the plain PC slice; behaviour is exactly as above.

Test Plan:
1. Reset, then if_pc=0x0000_0040 -> pred_idx=0x20, pred_taken=0; both stats = 0.
2. Three feedbacks, fb_idx=0x20, fb_pred_taken=0, fb_mispredict=1 -> cnt 01->10->11->11 (saturates); pred_taken=1 for if_pc=0x40 from the cycle after the first update; stat_branches=3, stat_mispredicts=3.
3. Same-cycle read and write: if_pc=0x40 with a fb_valid update to idx 0x20 that turns cnt 01 into 10 -> pred_taken=0 that cycle and 1 the next.
4. Strong-NT floor: feedback fb_pred_taken=0, fb_mispredict=0 on an entry at 00 -> stays 00; stat_branches increments, stat_mispredicts unchanged.
5. Aliasing: if_pc=0x40 and if_pc=0xC0 (IDX_W=6) -> same pred_idx 0x20 and same prediction; a compressed PC 0x42 maps to idx 0x21.
6. rst_n=0 in the same cycle as fb_valid=1 to an entry at 11 -> entry = 01 afterwards and stats = 0. With BP_GSHARE_EN: after actual outcomes T, T, NT, ghr=0b000110 and if_pc=0x40 gives pred_idx=0x26.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: IF-side bimodal predictor built from a table of 2-bit
// saturating counters. The table is trained from EX branch feedback, and the
// block keeps saturating counts of resolved branches and mispredictions.
// Optional build macro BP_GSHARE_EN turns on gshare indexing, where a global
// history register is XORed into the PC-derived index.

// One table entry: a 2-bit saturating up/down counter.
module bp_counter #(
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       upd,
    input  logic       act,
    output logic [1:0] cnt
);

    // Move toward taken (act=1) or not-taken (act=0), clamping at the ends.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= CNT_INIT;
        end else if (upd) begin
            if (act) begin
                if (cnt != 2'b11) cnt <= cnt + 2'd1;
            end else begin
                if (cnt != 2'b00) cnt <= cnt - 2'd1;
            end
        end
    end

endmodule

module branch_predictor #(
    parameter int         IDX_W    = 6,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_pc,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_idx,
    input  logic             fb_valid,
    input  logic [IDX_W-1:0] fb_idx,
    input  logic             fb_pred_taken,
    input  logic             fb_mispredict,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispredicts
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0][1:0] cnt;
    logic                  act;
    logic [IDX_W-1:0]      pc_idx;

    // Bit 0 is never used for indexing (instructions are at least 2-byte
    // aligned), and the PC bits above the index are dropped.
    logic unused_pc;
    assign unused_pc = ^{if_pc[31:IDX_W+1], if_pc[0]};

    // The real outcome is recovered from what we guessed and whether EX
    // flagged that guess as wrong.
    assign act    = fb_pred_taken ^ fb_mispredict;
    assign pc_idx = if_pc[IDX_W:1];

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr;

    // Global history: shift in each resolved outcome. The new history
    // affects indexing from the next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n)        ghr <= '0;
        else if (fb_valid) ghr <= {ghr[IDX_W-2:0], act};
    end

    assign pred_idx = pc_idx ^ ghr;
`else
    assign pred_idx = pc_idx;
`endif

    // Reads return the table state from before this edge's update. There is
    // no write bypass.
    assign pred_taken = cnt[pred_idx][1];

    for (genvar g = 0; g < DEPTH; g++) begin : g_tbl
        bp_counter #(.CNT_INIT(CNT_INIT)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .upd   (fb_valid && (fb_idx == IDX_W'(g))),
            .act   (act),
            .cnt   (cnt[g])
        );
    end

    // Performance counters. They hold at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (fb_valid) begin
            if (stat_branches != '1)
                stat_branches <= stat_branches + 32'd1;
            if (fb_mispredict && (stat_mispredicts != '1))
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor (IDX_W=6).
// Each vector is driven after a falling edge. Outputs are sampled 1ns later,
// before the next rising edge, so they show the state left by earlier vectors.
module tb_branch_predictor;

    localparam int IDX_W = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      if_pc;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_idx;
    logic             fb_valid;
    logic [IDX_W-1:0] fb_idx;
    logic             fb_pred_taken;
    logic             fb_mispredict;
    logic [31:0]      stat_branches;
    logic [31:0]      stat_mispredicts;

    always #5 clk = ~clk;

    branch_predictor #(.IDX_W(IDX_W), .CNT_INIT(2'b01)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_idx         (pred_idx),
        .fb_valid         (fb_valid),
        .fb_idx           (fb_idx),
        .fb_pred_taken    (fb_pred_taken),
        .fb_mispredict    (fb_mispredict),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    typedef struct {
        logic             chk;
        logic             rst_n;
        logic [31:0]      pc;
        logic             fbv;
        logic [IDX_W-1:0] fidx;
        logic             fpt;
        logic             fmp;
        logic             e_taken;
        logic [IDX_W-1:0] e_idx;
        logic [31:0]      e_br;
        logic [31:0]      e_mp;
    } vec_t;

    vec_t vecs[64];
    int   nvec   = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic chk, input logic r, input logic [31:0] pc,
                       input logic fbv, input logic [IDX_W-1:0] fidx,
                       input logic fpt, input logic fmp, input logic et,
                       input logic [IDX_W-1:0] ei, input int ebr, input int emp);
        vecs[nvec] = '{chk, r, pc, fbv, fidx, fpt, fmp, et, ei, ebr, emp};
        nvec++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        //  chk rst pc            fbv idx    pt mp | taken idx   br mp
`ifndef BP_GSHARE_EN
        add(0, 0, 32'h40, 1, 6'h20, 0, 1,  0, 6'h20, 0, 0); // reset overrides feedback
        add(1, 1, 32'h40, 0, 6'h00, 0, 0,  0, 6'h20, 0, 0); // reset state
        add(1, 1, 32'h40, 1, 6'h20, 0, 1,  0, 6'h20, 0, 0); // same-cycle: 01->10, shows 0
        add(1, 1, 32'h40, 1, 6'h20, 0, 1,  1, 6'h20, 1, 1); // 10->11
        add(1, 1, 32'h40, 1, 6'h20, 0, 1,  1, 6'h20, 2, 2); // 11 stays 11
        add(1, 1, 32'h40, 0, 6'h00, 1, 1,  1, 6'h20, 3, 3); // fb_valid=0 ignores pt/mp
        add(1, 1, 32'hC0, 0, 6'h00, 0, 0,  1, 6'h20, 3, 3); // alias of 0x40
        add(1, 1, 32'h42, 0, 6'h00, 0, 0,  0, 6'h21, 3, 3); // compressed PC -> 0x21
        add(1, 1, 32'h42, 1, 6'h21, 0, 0,  0, 6'h21, 3, 3); // 01->00
        add(1, 1, 32'h42, 1, 6'h21, 0, 0,  0, 6'h21, 4, 3); // 00 floor
        add(1, 1, 32'h42, 1, 6'h21, 0, 1,  0, 6'h21, 5, 3); // 00->01
        add(1, 1, 32'h42, 1, 6'h21, 1, 0,  0, 6'h21, 6, 4); // 01->10
        add(1, 1, 32'h42, 0, 6'h00, 0, 0,  1, 6'h21, 7, 4);
        add(1, 1, 32'h44, 1, 6'h22, 1, 0,  0, 6'h22, 7, 4); // same-cycle on 0x22
        add(1, 1, 32'h44, 0, 6'h00, 0, 0,  1, 6'h22, 8, 4); // visible next cycle
        add(1, 0, 32'h40, 1, 6'h20, 1, 0,  1, 6'h20, 8, 4); // reset while 0x20 is at 11
        add(1, 1, 32'h40, 0, 6'h00, 0, 0,  0, 6'h20, 0, 0); // back to 01, stats cleared
        add(1, 1, 32'h42, 0, 6'h00, 0, 0,  0, 6'h21, 0, 0); // 0x21 training discarded
        add(1, 1, 32'h40, 1, 6'h20, 1, 0,  0, 6'h20, 0, 0); // 01->10
        add(1, 1, 32'h40, 1, 6'h20, 1, 0,  1, 6'h20, 1, 0); // 10->11
        add(1, 1, 32'h40, 1, 6'h20, 1, 1,  1, 6'h20, 2, 0); // act=0: 11->10
        add(1, 1, 32'h40, 0, 6'h00, 1, 1,  1, 6'h20, 3, 1);
        add(1, 1, 32'h40, 1, 6'h20, 1, 1,  1, 6'h20, 3, 1); // 10->01
        add(1, 1, 32'h40, 0, 6'h00, 0, 0,  0, 6'h20, 4, 2);
`else
        add(0, 0, 32'h40, 1, 6'h20, 0, 1,  0, 6'h20, 0, 0);
        add(1, 1, 32'h40, 0, 6'h00, 0, 0,  0, 6'h20, 0, 0); // ghr=0
        add(1, 1, 32'h40, 1, 6'h01, 1, 0,  0, 6'h20, 0, 0); // T
        add(1, 1, 32'h40, 1, 6'h01, 1, 0,  0, 6'h21, 1, 0); // T
        add(1, 1, 32'h40, 1, 6'h01, 0, 0,  0, 6'h23, 2, 0); // NT
        add(1, 1, 32'h40, 0, 6'h00, 0, 0,  0, 6'h26, 3, 0); // ghr=000110
        add(1, 1, 32'h0E, 0, 6'h00, 0, 0,  1, 6'h01, 3, 0); // 0x07^0x06 -> entry at 10
        add(1, 0, 32'h0E, 1, 6'h01, 1, 0,  1, 6'h01, 3, 0); // reset beats feedback
        add(1, 1, 32'h0E, 0, 6'h00, 0, 0,  0, 6'h07, 0, 0); // ghr cleared
        add(1, 1, 32'h02, 0, 6'h00, 0, 0,  0, 6'h01, 0, 0); // training discarded
`endif

        rst_n = 1'b0; if_pc = '0; fb_valid = 1'b0; fb_idx = '0;
        fb_pred_taken = 1'b0; fb_mispredict = 1'b0;

        for (int i = 0; i < nvec; i++) begin
            @(negedge clk);
            rst_n         = vecs[i].rst_n;
            if_pc         = vecs[i].pc;
            fb_valid      = vecs[i].fbv;
            fb_idx        = vecs[i].fidx;
            fb_pred_taken = vecs[i].fpt;
            fb_mispredict = vecs[i].fmp;
            #1;
            if (vecs[i].chk) begin
                check($sformatf("v%0d pred_taken", i), 32'(pred_taken), 32'(vecs[i].e_taken));
                check($sformatf("v%0d pred_idx", i), 32'(pred_idx), 32'(vecs[i].e_idx));
                check($sformatf("v%0d stat_branches", i), stat_branches, vecs[i].e_br);
                check($sformatf("v%0d stat_mispredicts", i), stat_mispredicts, vecs[i].e_mp);
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
